// File: rtl/order_scheduler.sv
// -----------------------------------------------------------------------------
// order_scheduler
//
// Front-end sequencer for the matching engine's price inputs. It arbitrates
// NUM_SRC order sources round-robin and drives at most one order per cycle onto
// the engine's buy/sell price inputs. In any cycle with no transfer it drives an
// idle bubble instead.
//
// An IDLE/RUN/FLUSH state machine controls arbitration. FLUSH drives DEPTH
// bubble cycles so the engine's price queues drain. The engine's level match
// output is turned into one-cycle trade events, and a saturating counter
// tracks how many have occurred.
//
// Handshake: a source order transfers at a rising clk edge when src_valid[i]
// and src_ready[i] are both high in the cycle before that edge. src_ready is a
// combinational one-hot grant and never depends on src_valid[i] of the same
// source being held; a source may drop valid at any time before transfer.
//
// Ports
//   clk, reset        clock (rising edge) and synchronous active-high reset
//   enable            level, 1 = run arbitration
//   flush_req         pulse, request queue drain
//   src_valid/side    per-source order valid and side (1 = buy, 0 = sell)
//   src_price         packed prices, source i at [i*PRICE_W +: PRICE_W]
//   src_ready         one-hot grant (combinational)
//   eng_buy_price     registered engine buy price (bubble = 0)
//   eng_sell_price    registered engine sell price (bubble = all-ones)
//   eng_match         engine match level
//   eng_trade_price   engine trade price
//   trade_valid       one-cycle registered trade event
//   trade_price       price captured with trade_valid
//   trade_count       saturating trade event count
//   busy              1 while in FLUSH
//   state             FSM state: IDLE = 00, RUN = 01, FLUSH = 10
// -----------------------------------------------------------------------------
module order_scheduler #(
    parameter int NUM_SRC = 4,
    parameter int PRICE_W = 8,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       flush_req,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC-1:0]         src_side,
    input  logic [NUM_SRC*PRICE_W-1:0] src_price,
    output logic [NUM_SRC-1:0]         src_ready,
    output logic [PRICE_W-1:0]         eng_buy_price,
    output logic [PRICE_W-1:0]         eng_sell_price,
    input  logic                       eng_match,
    input  logic [PRICE_W-1:0]         eng_trade_price,
    output logic                       trade_valid,
    output logic [PRICE_W-1:0]         trade_price,
    output logic [CNT_W-1:0]           trade_count,
    output logic                       busy,
    output logic [1:0]                 state
);

    localparam int PTR_W = $clog2(NUM_SRC);
    localparam int FC_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t             st;
    logic [PTR_W-1:0]   rr_ptr;
    logic [FC_W-1:0]    flush_cnt;
    logic               match_d;

    // Grant search result
    logic               grant_any;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_SRC-1:0] grant;
    int                 idx;

    logic [PRICE_W-1:0] sel_price;
    logic               sel_side;
    logic               trade_rise;

    // Round-robin search starting at rr_ptr. Arbitration is suppressed in the
    // cycle RUN is being left (flush_req or enable low), so no order is lost
    // to a state change.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant     = '0;
        idx       = 0;
        if (st == RUN && enable && !flush_req) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_SRC;
                if (!grant_any && src_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = PTR_W'(idx);
                end
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign src_ready = grant;
    assign sel_price = src_price[int'(grant_idx)*PRICE_W +: PRICE_W];
    assign sel_side  = src_side[grant_idx];

    // Trade events are only reported outside FLUSH; match_d still tracks the
    // level so a match held across the end of FLUSH is not reported late.
    assign trade_rise = eng_match && !match_d && (st != FLUSH);

    assign state = st;
    assign busy  = (st == FLUSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            st             <= IDLE;
            rr_ptr         <= '0;
            flush_cnt      <= '0;
            match_d        <= 1'b0;
            eng_buy_price  <= '0;
            eng_sell_price <= '1;
            trade_valid    <= 1'b0;
            trade_price    <= '0;
            trade_count    <= '0;
        end else begin
            // Engine price ports: order on transfer, bubble otherwise.
            if (grant_any) begin
                if (sel_side) begin
                    eng_buy_price  <= sel_price;
                    eng_sell_price <= '1;
                end else begin
                    eng_buy_price  <= '0;
                    eng_sell_price <= sel_price;
                end
                rr_ptr <= (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                eng_buy_price  <= '0;
                eng_sell_price <= '1;
            end

            case (st)
                IDLE: begin
                    if (flush_req) begin
                        st        <= FLUSH;
                        flush_cnt <= '0;
                    end else if (enable) begin
                        st <= RUN;
                    end
                end
                RUN: begin
                    if (flush_req) begin
                        st        <= FLUSH;
                        flush_cnt <= '0;
                    end else if (!enable) begin
                        st <= IDLE;
                    end
                end
                FLUSH: begin
                    // flush_req and enable are ignored here; the count only
                    // runs forward so a repeated request cannot extend FLUSH.
                    if (flush_cnt == FC_W'(DEPTH - 1)) begin
                        st        <= IDLE;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: begin
                    st <= IDLE;
                end
            endcase

            match_d     <= eng_match;
            trade_valid <= trade_rise;
            if (trade_rise) begin
                trade_price <= eng_trade_price;
                if (trade_count != '1) begin
                    trade_count <= trade_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_order_scheduler.sv
module tb_order_scheduler;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        flush_req;
    logic [3:0]  src_valid;
    logic [3:0]  src_side;
    logic [31:0] src_price;
    logic [3:0]  src_ready;
    logic [7:0]  eng_buy_price;
    logic [7:0]  eng_sell_price;
    logic        eng_match;
    logic [7:0]  eng_trade_price;
    logic        trade_valid;
    logic [7:0]  trade_price;
    logic [15:0] trade_count;
    logic        busy;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    order_scheduler #(
        .NUM_SRC(4),
        .PRICE_W(8),
        .DEPTH(8),
        .CNT_W(16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .flush_req      (flush_req),
        .src_valid      (src_valid),
        .src_side       (src_side),
        .src_price      (src_price),
        .src_ready      (src_ready),
        .eng_buy_price  (eng_buy_price),
        .eng_sell_price (eng_sell_price),
        .eng_match      (eng_match),
        .eng_trade_price(eng_trade_price),
        .trade_valid    (trade_valid),
        .trade_price    (trade_price),
        .trade_count    (trade_count),
        .busy           (busy),
        .state          (state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_ready;
        logic [7:0] exp_buy;
        logic [7:0] exp_sell;
    } vec_t;

    vec_t vecs[12];
    int   pulses;
    int   fl_n;

    initial begin
        // Fixed source orders: src0 sell 0x10, src1 buy 0x21, src2 sell 0x32, src3 buy 0x43
        vecs[0]  = '{4'b1111, 4'b0001, 8'h00, 8'h10};
        vecs[1]  = '{4'b1111, 4'b0010, 8'h21, 8'hFF};
        vecs[2]  = '{4'b1111, 4'b0100, 8'h00, 8'h32};
        vecs[3]  = '{4'b1111, 4'b1000, 8'h43, 8'hFF};
        vecs[4]  = '{4'b1111, 4'b0001, 8'h00, 8'h10};
        vecs[5]  = '{4'b0010, 4'b0010, 8'h21, 8'hFF};
        vecs[6]  = '{4'b0010, 4'b0010, 8'h21, 8'hFF};
        vecs[7]  = '{4'b1010, 4'b1000, 8'h43, 8'hFF};
        vecs[8]  = '{4'b1010, 4'b0010, 8'h21, 8'hFF};
        vecs[9]  = '{4'b0000, 4'b0000, 8'h00, 8'hFF};
        vecs[10] = '{4'b0101, 4'b0100, 8'h00, 8'h32};
        vecs[11] = '{4'b0001, 4'b0001, 8'h00, 8'h10};

        reset           = 1'b1;
        enable          = 1'b0;
        flush_req       = 1'b0;
        src_valid       = 4'b0000;
        src_side        = 4'b1010;
        src_price       = {8'h43, 8'h32, 8'h21, 8'h10};
        eng_match       = 1'b0;
        eng_trade_price = 8'h00;

        // 1. reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_buy",   32'(eng_buy_price),  32'h00);
        chk("rst_sell",  32'(eng_sell_price), 32'hFF);
        chk("rst_ready", 32'(src_ready),      32'h0);
        chk("rst_state", 32'(state),          32'h0);
        chk("rst_count", 32'(trade_count),    32'h0);
        chk("rst_tv",    32'(trade_valid),    32'h0);
        chk("rst_busy",  32'(busy),           32'h0);
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        chk("run_state", 32'(state), 32'h1);

        // 2. round-robin grant table
        for (int i = 0; i < 12; i++) begin
            src_valid = vecs[i].valid;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(src_ready), 32'(vecs[i].exp_ready));
            tick();
            chk($sformatf("vec%0d_buy", i),  32'(eng_buy_price),  32'(vecs[i].exp_buy));
            chk($sformatf("vec%0d_sell", i), 32'(eng_sell_price), 32'(vecs[i].exp_sell));
        end

        // 3. src2 buy 0x64, then src0 sell 0x5A
        src_price[23:16] = 8'h64;
        src_side[2]      = 1'b1;
        src_valid        = 4'b0100;
        #1;
        chk("buy64_ready", 32'(src_ready), 32'h4);
        tick();
        chk("buy64_buy",  32'(eng_buy_price),  32'h64);
        chk("buy64_sell", 32'(eng_sell_price), 32'hFF);
        src_price[7:0] = 8'h5A;
        src_valid      = 4'b0001;
        #1;
        chk("sell5a_ready", 32'(src_ready), 32'h1);
        tick();
        chk("sell5a_buy",  32'(eng_buy_price),  32'h00);
        chk("sell5a_sell", 32'(eng_sell_price), 32'h5A);
        src_valid = 4'b0000;
        tick();
        chk("bubble_buy",  32'(eng_buy_price),  32'h00);
        chk("bubble_sell", 32'(eng_sell_price), 32'hFF);

        // 4. match held 5 cycles -> single trade event
        eng_match       = 1'b1;
        eng_trade_price = 8'h5F;
        pulses          = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (trade_valid) pulses++;
            if (i == 0) begin
                chk("trade_valid", 32'(trade_valid), 32'h1);
                chk("trade_price", 32'(trade_price), 32'h5F);
                chk("trade_count", 32'(trade_count), 32'h1);
            end
        end
        chk("trade_pulses", 32'(pulses), 32'h1);
        eng_match       = 1'b0;
        eng_trade_price = 8'h11;
        tick();
        chk("trade_hold_price", 32'(trade_price), 32'h5F);

        // 5. flush with sources valid; second request and a match rise inside FLUSH
        src_valid = 4'b1111;
        flush_req = 1'b1;
        #1;
        chk("flreq_ready", 32'(src_ready), 32'h0);
        tick();
        flush_req = 1'b0;
        fl_n      = 0;
        while (busy && fl_n < 20) begin
            chk($sformatf("fl%0d_state", fl_n), 32'(state),          32'h2);
            chk($sformatf("fl%0d_ready", fl_n), 32'(src_ready),      32'h0);
            chk($sformatf("fl%0d_buy", fl_n),   32'(eng_buy_price),  32'h00);
            chk($sformatf("fl%0d_sell", fl_n),  32'(eng_sell_price), 32'hFF);
            chk($sformatf("fl%0d_tv", fl_n),    32'(trade_valid),    32'h0);
            if (fl_n == 2) eng_match = 1'b1;
            if (fl_n == 4) flush_req = 1'b1;
            fl_n++;
            tick();
            flush_req = 1'b0;
        end
        chk("flush_len",   32'(fl_n),        32'd8);
        chk("flush_idle",  32'(state),       32'h0);
        chk("flush_tv",    32'(trade_valid), 32'h0);
        chk("flush_count", 32'(trade_count), 32'h1);
        eng_match = 1'b0;

        // 6. reset in the middle of a flush
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("fl2_state", 32'(state), 32'h2);
        repeat (3) tick();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        reset = 1'b0;
        chk("rst2_state", 32'(state),          32'h0);
        chk("rst2_busy",  32'(busy),           32'h0);
        chk("rst2_buy",   32'(eng_buy_price),  32'h00);
        chk("rst2_sell",  32'(eng_sell_price), 32'hFF);
        chk("rst2_count", 32'(trade_count),    32'h0);
        chk("rst2_ready", 32'(src_ready),      32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
